// File: rtl/slc3_input_conditioner.sv
`default_nettype none
// ============================================================================
// slc3_input_conditioner
//   Synchronizes SLC-3 switches; synchronizes, debounces and edge-detects the
//   active-low Run / Continue buttons.
//   Rev 1.0
// ============================================================================
module slc3_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run_btn,
  input  logic       Continue_btn,
  input  logic [9:0] SW_raw,
  output logic       Run_level,
  output logic       Continue_level,
  output logic       Run_pulse,
  output logic       Continue_pulse,
  output logic [9:0] SW_sync
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] btn_raw;
  logic [1:0] level_w;
  logic [1:0] pulse_w;
  logic [9:0] sw_meta_q;
  logic [9:0] sw_sync_q;

  assign btn_raw = {Continue_btn, Run_btn};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= SW_raw;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Index 0 = Run, index 1 = Continue; buttons are handled in the raw
  // active-low polarity until the level output is formed.
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic             meta_q;
    logic             sync_q;
    logic             stable_q;
    logic             stable_d;
    logic             pulse_q;
    logic             pulse_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync_q != stable_q) begin
        if (cnt_q == CNT_LAST) begin
          stable_d = sync_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Press = stable moving from released (1) to pressed (0).
      pulse_d = stable_q & ~stable_d;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        meta_q   <= 1'b1;
        sync_q   <= 1'b1;
        stable_q <= 1'b1;
        cnt_q    <= '0;
        pulse_q  <= 1'b0;
      end else begin
        meta_q   <= btn_raw[i];
        sync_q   <= meta_q;
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
        pulse_q  <= pulse_d;
      end
    end

    assign level_w[i] = ~stable_q;
    assign pulse_w[i] = pulse_q;
  end

  assign Run_level      = level_w[0];
  assign Continue_level = level_w[1];
  assign Run_pulse      = pulse_w[0];
  assign Continue_pulse = pulse_w[1];
  assign SW_sync        = sw_sync_q;

endmodule
`default_nettype wire

// File: tb/tb_slc3_input_conditioner.sv
`default_nettype none
// ============================================================================
// tb_slc3_input_conditioner
//   Randomized bench with a cycle-level reference model, plus directed cases.
//   Rev 1.0
// ============================================================================
module tb_slc3_input_conditioner;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run_btn;
  logic       cont_btn;
  logic [9:0] sw_raw;
  logic       run_level;
  logic       cont_level;
  logic       run_pulse;
  logic       cont_pulse;
  logic [9:0] sw_sync;

  int n_checks = 0;
  int n_fail   = 0;

  slc3_input_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
    .Clk            (clk),
    .Reset_n        (rst_n),
    .Run_btn        (run_btn),
    .Continue_btn   (cont_btn),
    .SW_raw         (sw_raw),
    .Run_level      (run_level),
    .Continue_level (cont_level),
    .Run_pulse      (run_pulse),
    .Continue_pulse (cont_pulse),
    .SW_sync        (sw_sync)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: buttons tracked as "pressed" booleans; a new pressed
  // state is accepted once the synchronized sample has disagreed with the
  // accepted state for DEB consecutive edges.
  logic [1:0] m_meta    = 2'b00;
  logic [1:0] m_sync    = 2'b00;
  logic [1:0] m_pressed = 2'b00;
  logic [1:0] m_pulse   = 2'b00;
  int         m_run_len [2] = '{0, 0};
  logic [9:0] m_sw_meta = '0;
  logic [9:0] m_sw      = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_meta = 2'b00; m_sync = 2'b00; m_pressed = 2'b00; m_pulse = 2'b00;
      m_run_len[0] = 0; m_run_len[1] = 0;
      m_sw_meta = '0; m_sw = '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        m_pulse[b] = 1'b0;
        if (m_sync[b] != m_pressed[b]) begin
          m_run_len[b] = m_run_len[b] + 1;
          if (m_run_len[b] == DEB) begin
            m_pressed[b] = m_sync[b];
            m_run_len[b] = 0;
            m_pulse[b]   = m_pressed[b];
          end
        end else begin
          m_run_len[b] = 0;
        end
      end
      m_sync    = m_meta;
      m_meta    = ~{cont_btn, run_btn};
      m_sw      = m_sw_meta;
      m_sw_meta = sw_raw;
    end
  end

  always @(negedge clk) begin
    check_eq("run_level",  32'(run_level),  32'(m_pressed[0]));
    check_eq("cont_level", 32'(cont_level), 32'(m_pressed[1]));
    check_eq("run_pulse",  32'(run_pulse),  32'(m_pulse[0]));
    check_eq("cont_pulse", 32'(cont_pulse), 32'(m_pulse[1]));
    check_eq("sw_sync",    32'(sw_sync),    32'(m_sw));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Observe n edges; report first edge index with the signal high and count.
  task automatic watch_pulse(input int n, input bit sel_cont,
                             output int first, output int cnt);
    first = -1;
    cnt   = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if ((sel_cont ? cont_pulse : run_pulse) === 1'b1) begin
        if (first < 0) first = i;
        cnt++;
      end
    end
  endtask

  int first_r, cnt_r, first_c, cnt_c, lvl_cnt, fall_idx;
  int hold_r, hold_c;

  initial begin
    rst_n    = 1'b0;
    run_btn  = 1'b1;
    cont_btn = 1'b1;
    sw_raw   = 10'h3FF;
    repeat (3) tick();
    check_eq("rst_outputs", 32'({run_level, cont_level, run_pulse, cont_pulse, sw_sync}), 32'd0);

    // Reset release: switches appear two edges later, buttons stay idle.
    rst_n = 1'b1;
    repeat (2) tick();
    check_eq("sw_after_2", 32'(sw_sync), 32'h3FF);
    repeat (4) tick();
    check_eq("idle_levels", 32'({run_level, cont_level, run_pulse, cont_pulse}), 32'd0);

    // Held Run press: one pulse after edge 5, release falls 5 edges later.
    run_btn = 1'b0;
    watch_pulse(20, 1'b0, first_r, cnt_r);
    check_eq("run_pulse_edge", 32'(first_r), 32'd5);
    check_eq("run_pulse_cnt",  32'(cnt_r),   32'd1);
    check_eq("run_level_held", 32'(run_level), 32'd1);
    run_btn  = 1'b1;
    fall_idx = -1;
    cnt_r    = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (run_level === 1'b0 && fall_idx < 0) fall_idx = i;
      if (run_pulse === 1'b1) cnt_r++;
    end
    check_eq("run_release_edge", 32'(fall_idx), 32'd5);
    check_eq("run_release_pulse", 32'(cnt_r), 32'd0);

    // Continue bounce shorter than the debounce window never registers.
    lvl_cnt = 0;
    for (int rep = 0; rep < 2; rep++) begin
      cont_btn = 1'b0;
      for (int i = 0; i < 3; i++) begin tick(); lvl_cnt += (cont_level | cont_pulse); end
      cont_btn = 1'b1;
      tick(); lvl_cnt += (cont_level | cont_pulse);
    end
    for (int i = 0; i < 12; i++) begin tick(); lvl_cnt += (cont_level | cont_pulse); end
    check_eq("cont_bounce", 32'(lvl_cnt), 32'd0);

    // Simultaneous presses give simultaneous single pulses.
    run_btn  = 1'b0;
    cont_btn = 1'b0;
    first_r = -1; first_c = -1; cnt_r = 0; cnt_c = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (run_pulse)  begin if (first_r < 0) first_r = i; cnt_r++; end
      if (cont_pulse) begin if (first_c < 0) first_c = i; cnt_c++; end
    end
    check_eq("both_same_edge", 32'(first_c), 32'(first_r));
    check_eq("both_run_edge",  32'(first_r), 32'd5);
    check_eq("both_run_cnt",   32'(cnt_r),   32'd1);
    check_eq("both_cont_cnt",  32'(cnt_c),   32'd1);
    run_btn  = 1'b1;
    cont_btn = 1'b1;
    repeat (12) tick();

    // Reset mid-debounce, button held through release: one fresh pulse.
    run_btn = 1'b0;
    watch_pulse(3, 1'b0, first_r, cnt_r);
    check_eq("pre_reset_pulse", 32'(cnt_r), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("reset_async_clear", 32'({run_level, run_pulse}), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    watch_pulse(20, 1'b0, first_r, cnt_r);
    check_eq("post_reset_edge", 32'(first_r), 32'd5);
    check_eq("post_reset_cnt",  32'(cnt_r),   32'd1);
    run_btn = 1'b1;
    repeat (12) tick();

    // Randomized phase: buttons held for random spans around the window.
    hold_r = 0;
    hold_c = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold_r == 0) begin run_btn = ~run_btn; hold_r = $urandom_range(1, 9); end
      if (hold_c == 0) begin cont_btn = ~cont_btn; hold_c = $urandom_range(1, 9); end
      hold_r--;
      hold_c--;
      sw_raw = 10'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/slc3_input_conditioner.md
SLC3_INPUT_CONDITIONER -- requirements
Module: slc3_input_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 50000, number of consecutive clocks a synchronized button must hold a new value before it is accepted; legal range >= 1.
REQ-002 Port: Clk  input  1  system clock; all state changes on the rising edge.
REQ-003 Port: Reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: Run_btn  input  1  raw Run push-button, active-low, asynchronous to Clk, may bounce.
REQ-005 Port: Continue_btn  input  1  raw Continue push-button, active-low, asynchronous to Clk, may bounce.
REQ-006 Port: SW_raw  input  10  raw slide switches, asynchronous to Clk.
REQ-007 Port: Run_level  output  1  debounced Run state, active-high (1 = pressed).
REQ-008 Port: Continue_level  output  1  debounced Continue state, active-high (1 = pressed).
REQ-009 Port: Run_pulse  output  1  one-cycle strobe on each debounced Run press.
REQ-010 Port: Continue_pulse  output  1  one-cycle strobe on each debounced Continue press.
REQ-011 Port: SW_sync  output  10  synchronized switches for the SLC-3 core.

Function
REQ-012 Each button and each SW_raw bit SHALL pass through a two-flop synchronizer; no combinational path from any raw input to any output.
REQ-013 SW_sync SHALL equal SW_raw delayed by exactly 2 clock edges; switches are not debounced.
REQ-014 Each button SHALL have an independent debouncer: a stable register, plus a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-015 Per edge: if the synchronized value equals the stable value -> counter cleared; else if counter == DEBOUNCE_CYCLES-1 -> stable takes the synchronized value, counter cleared; else counter increments.
REQ-016 Any return to the stable value before acceptance SHALL clear the counter, discarding partial progress (bounce rejection).
REQ-017 *_level SHALL be the inverse of the stable register (button low -> level 1).
REQ-018 *_pulse SHALL be registered, high for exactly one cycle, asserted on the same edge that the stable register changes from released to pressed; no pulse on release.
REQ-019 Latency: raw button first sampled low at edge 0 and held -> *_level and *_pulse high after edge DEBOUNCE_CYCLES+1; pulse low again after edge DEBOUNCE_CYCLES+2.
REQ-020 Release latency SHALL be identical (DEBOUNCE_CYCLES+1 edges) with no pulse.
REQ-021 A held button SHALL produce exactly one pulse regardless of hold duration; counter never wraps while input equals stable.
REQ-022 Run and Continue SHALL be fully independent; simultaneous presses produce simultaneous pulses.

Reset
REQ-023 While Reset_n = 0: all synchronizer flops for buttons = 1 (released), stable registers = released, counters = 0, *_level = 0, *_pulse = 0, SW synchronizer flops and SW_sync = 0.
REQ-024 Reset assertion mid-debounce SHALL abandon the count immediately; no pulse is issued for that press.
REQ-025 A button held low across reset release SHALL be treated as a new press: one pulse after the REQ-019 latency measured from the first post-reset sampling edge.

Verification (DEBOUNCE_CYCLES = 4)
REQ-026 Reset pulse low, all raw buttons 1, SW_raw = 10'h3FF -> during reset all outputs 0; after release SW_sync = 10'h3FF after 2 edges, levels/pulses stay 0.
REQ-027 Run_btn driven low and held 20 cycles -> Run_pulse high for exactly 1 cycle after edge 5, Run_level 1 until release, then 0 five edges after release sampling, no second pulse.
REQ-028 Continue_btn bounce pattern low 3 / high 1 / low 3 / high 1, then high -> Continue_level and Continue_pulse never assert.
REQ-029 Run_btn and Continue_btn both driven low on the same edge and held -> both pulses assert on the same cycle, each exactly once.
REQ-030 Run_btn low, Reset_n asserted after 3 edges, released with button still low -> no pulse before reset, exactly one Run_pulse 5 edges after the first post-reset sampling edge.
